lock_sequencer: RTL
===================

Name: lock_sequencer

Overview:
- Central mode controller for the six-digit combination lock.
- Owns the mode state machine (set password / locked / lockout / unlocked), the stored password, the consecutive-failure counter and the lockout countdown.
- Sequences the digit-entry unit through a start/done handshake.
- Tells the display path when to blank all six seven-segment digits and which mode is active.

Parameters:
- CODE_W, 24, width of the entered/stored code (6 digits × 4 bits).
- MAX_FAILS, 3, number of consecutive wrong codes that triggers lockout (≥1).
- LOCKOUT_CYCLES, 1000, number of clock cycles spent in lockout (≥1).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-high.
- entry_done  in  1  one-cycle pulse from the entry unit; entry_code is valid in the same cycle.
- entry_code  in  CODE_W  code assembled by the entry unit.
- btn_change  in  1  one-cycle pulse, already debounced; in unlocked mode, go to set-password.
- btn_relock  in  1  one-cycle pulse, already debounced; in unlocked mode, relock with the same password.
- entry_start  out  1  one-cycle pulse; the entry unit clears and begins collecting digits.
- disp_clear  out  1  one-cycle pulse; blank all six displays.
- mode  out  2  00 set, 01 locked, 10 lockout, 11 unlocked.
- unlocked  out  1  high while mode==11.
- fails  out  clog2(MAX_FAILS+1)  current consecutive-failure count.
- lockout_left  out  clog2(LOCKOUT_CYCLES)  remaining lockout cycles; 0 outside lockout.

Behaviour:
- All outputs are decoded from registered state only; there is no combinational input-to-output path.
- Internal states: ARM_SET, WAIT_SET, ARM_LOCK, WAIT_LOCK, CHECK, LOCKOUT, UNLOCKED.
- Mode mapping:
  - ARM_SET, WAIT_SET → mode 00.
  - ARM_LOCK, WAIT_LOCK, CHECK → mode 01.
  - LOCKOUT → mode 10.
  - UNLOCKED → mode 11.
- Reset:
  - rst=1 at a clock edge sets: state=ARM_SET, pw=0, cand=0, fails=0, timer=0.
  - During and immediately after reset, outputs read mode=00, unlocked=0, lockout_left=0.
  - The first cycle with rst=0 is ARM_SET, so entry_start=1 and disp_clear=1.
  - rst takes effect from any state, mid-entry or mid-lockout included.
- ARM_SET / ARM_LOCK:
  - Last exactly one cycle, with entry_start=1 and disp_clear=1.
  - Next state is WAIT_SET / WAIT_LOCK respectively.
  - entry_done in an ARM cycle is ignored.
- WAIT_SET: on entry_done, pw<=entry_code and fails<=0, then → ARM_LOCK.
- WAIT_LOCK: on entry_done, cand<=entry_code, then → CHECK.
- CHECK (one cycle, full CODE_W equality cand==pw):
  - Match: fails<=0, → UNLOCKED.
  - Mismatch with fails+1 < MAX_FAILS: fails<=fails+1, → ARM_LOCK.
  - Mismatch with fails+1 == MAX_FAILS: fails<=0, timer<=LOCKOUT_CYCLES-1, → LOCKOUT.
- Verdict latency: entry_done in cycle N → CHECK in N+1 → new state visible in N+2.
- Entering LOCKOUT or UNLOCKED: disp_clear=1 for the first cycle in that state. A registered entry flag is set on the transition and cleared after one cycle.
- LOCKOUT:
  - lockout_left=timer; timer decrements once per cycle.
  - In the cycle where timer==0, → ARM_LOCK.
  - LOCKOUT therefore lasts exactly LOCKOUT_CYCLES cycles.
  - Buttons and entry_done are ignored.
- UNLOCKED:
  - unlocked=1.
  - btn_relock → ARM_LOCK with pw unchanged and fails=0.
  - btn_change → ARM_SET.
  - Both pulses in the same cycle: btn_relock wins (the safe outcome).
- entry_done outside WAIT_SET/WAIT_LOCK is ignored.
- Buttons outside UNLOCKED are ignored.
- fails never exceeds MAX_FAILS-1 and never wraps.
- MAX_FAILS=1: the first mismatch goes straight to LOCKOUT.
- LOCKOUT_CYCLES=1: a one-cycle lockout, with lockout_left=0 throughout.

Test Plan:
1. Release rst → mode=00; entry_start and disp_clear high for exactly the first cycle, then low; fails=0, unlocked=0.
2. In WAIT_SET, entry_done with code 0x123456 → next cycle ARM_LOCK (mode 01, entry_start pulse). Then entry_done with 0x123456 → two cycles later mode=11, unlocked=1, disp_clear pulse, fails=0.
3. In WAIT_LOCK, three wrong codes (0x000001) → fails 1, then 2, then mode=10 with lockout_left=999 counting down by 1 per cycle. After exactly 1000 LOCKOUT cycles, mode=01 with an entry_start pulse and fails=0. entry_done and buttons asserted during LOCKOUT have no effect.
4. Two wrong codes then the correct code → fails reads 2 before the check, then mode=11 and fails=0. A subsequent single wrong code after relock gives fails=1, not a lockout.
5. In UNLOCKED, btn_change and btn_relock in the same cycle → mode=01, and the old code still unlocks. Then btn_change alone → mode=00 with an entry_start pulse; new code 0xABCDEF replaces the old one, and 0x123456 now fails.
6. rst asserted mid-LOCKOUT (lockout_left=500) and during WAIT_LOCK → next cycle mode=00, fails=0, lockout_left=0, pw=0. Also MAX_FAILS=1 and LOCKOUT_CYCLES=1 builds: lockout after one miss, lasting 1 cycle.

Source files
------------

// File: rtl/lock_sequencer_if.sv
// Bundle between the lock sequencer, the digit-entry unit, the buttons and the display path.
// master = sequencer side; slave = the surrounding datapath.
interface lock_sequencer_if #(
  parameter int CODE_W         = 24,
  parameter int MAX_FAILS      = 3,
  parameter int LOCKOUT_CYCLES = 1000
);
  localparam int FAIL_W = $clog2(MAX_FAILS + 1);
  localparam int LEFT_W = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;

  logic              entry_done;
  logic [CODE_W-1:0] entry_code;
  logic              btn_change;
  logic              btn_relock;
  logic              entry_start;
  logic              disp_clear;
  logic [1:0]        mode;
  logic              unlocked;
  logic [FAIL_W-1:0] fails;
  logic [LEFT_W-1:0] lockout_left;

  modport master (
    input  entry_done, entry_code, btn_change, btn_relock,
    output entry_start, disp_clear, mode, unlocked, fails, lockout_left
  );

  modport slave (
    output entry_done, entry_code, btn_change, btn_relock,
    input  entry_start, disp_clear, mode, unlocked, fails, lockout_left
  );
endinterface

// File: rtl/lock_sequencer.sv
// Mode controller for the six-digit lock: password store, failure count, lockout timer.
// Verdict two cycles after entry_done; all outputs decoded from registered state, no backpressure.
module lock_sequencer #(
  parameter int CODE_W         = 24,
  parameter int MAX_FAILS      = 3,
  parameter int LOCKOUT_CYCLES = 1000
) (
  input  logic              clk,
  input  logic              rst,
  lock_sequencer_if.master  bus
);
  localparam int FAIL_W = $clog2(MAX_FAILS + 1);
  localparam int LEFT_W = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;

  typedef enum logic [2:0] {
    ARM_SET, WAIT_SET, ARM_LOCK, WAIT_LOCK, CHECK, LOCKOUT, UNLOCKED
  } state_t;

  state_t            state_q, state_d;
  logic [CODE_W-1:0] pw_q, pw_d;
  logic [CODE_W-1:0] cand_q, cand_d;
  logic [FAIL_W-1:0] fails_q, fails_d;
  logic [LEFT_W-1:0] timer_q, timer_d;
  logic              enter_q, enter_d;
  logic              last_try;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ARM_SET;
      pw_q    <= '0;
      cand_q  <= '0;
      fails_q <= '0;
      timer_q <= '0;
      enter_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pw_q    <= pw_d;
      cand_q  <= cand_d;
      fails_q <= fails_d;
      timer_q <= timer_d;
      enter_q <= enter_d;
    end
  end

  assign last_try = (fails_q == FAIL_W'(MAX_FAILS - 1));

  always_comb begin
    state_d = state_q;
    pw_d    = pw_q;
    cand_d  = cand_q;
    fails_d = fails_q;
    timer_d = timer_q;
    case (state_q)
      ARM_SET:  state_d = WAIT_SET;
      WAIT_SET: begin
        if (bus.entry_done) begin
          pw_d    = bus.entry_code;
          fails_d = '0;
          state_d = ARM_LOCK;
        end
      end
      ARM_LOCK: state_d = WAIT_LOCK;
      WAIT_LOCK: begin
        if (bus.entry_done) begin
          cand_d  = bus.entry_code;
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (cand_q == pw_q) begin
          fails_d = '0;
          state_d = UNLOCKED;
        end else if (last_try) begin
          fails_d = '0;
          timer_d = LEFT_W'(LOCKOUT_CYCLES - 1);
          state_d = LOCKOUT;
        end else begin
          fails_d = fails_q + FAIL_W'(1);
          state_d = ARM_LOCK;
        end
      end
      LOCKOUT: begin
        if (timer_q == '0) state_d = ARM_LOCK;
        else               timer_d = timer_q - LEFT_W'(1);
      end
      UNLOCKED: begin
        // relock is checked first so a simultaneous press never drops protection
        if (bus.btn_relock) begin
          fails_d = '0;
          state_d = ARM_LOCK;
        end else if (bus.btn_change) begin
          state_d = ARM_SET;
        end
      end
      default: state_d = ARM_SET;
    endcase
  end

  assign enter_d = (state_d != state_q) && ((state_d == LOCKOUT) || (state_d == UNLOCKED));

  always_comb begin
    bus.mode = 2'b00;
    case (state_q)
      ARM_LOCK, WAIT_LOCK, CHECK: bus.mode = 2'b01;
      LOCKOUT:                    bus.mode = 2'b10;
      UNLOCKED:                   bus.mode = 2'b11;
      default:                    bus.mode = 2'b00;
    endcase
  end

  assign bus.entry_start  = (state_q == ARM_SET) || (state_q == ARM_LOCK);
  assign bus.disp_clear   = bus.entry_start || enter_q;
  assign bus.unlocked     = (state_q == UNLOCKED);
  assign bus.fails        = fails_q;
  assign bus.lockout_left = (state_q == LOCKOUT) ? timer_q : '0;
endmodule
